// File: rtl/pe_bilinear_pipe.sv
// pe_bilinear_pipe -- pipelined multi-channel bilinear interpolation PE.
//
// Three register stages:
//   S1 : fractional weights w00..w11, pixel bundles, round flag, tag
//   S2 : per-channel products p_ij = w_ij * a_ij
//   S3 : per-channel sum (+ optional half-LSB), shift, saturate -> b
//
// A single advance enable (en = !out_valid | out_ready) moves the whole
// pipe, bubbles included, so in_ready is simply en.
//
// Ports
//   clk, rst_n          clock / async active-low reset
//   in_valid, in_ready  input handshake
//   a00,a01,a10,a11     CH*DWIDTH neighbour pixels, channel k at [k*DWIDTH +: DWIDTH]
//   fx, fy              FWIDTH-bit unsigned fractions in [0,1)
//   round_en            1 = round half up, 0 = truncate (travels with the beat)
//   in_tag              TWIDTH sideband, carried unchanged
//   out_valid,out_ready output handshake
//   b                   CH*DWIDTH interpolated pixels
//   out_tag             tag of the beat on b

// Per-channel S2/S3 slice. Weights are shared by all lanes.
//   en_i        pipe advance enable
//   w*_i        S1 weights (2*FWIDTH+1 bits)
//   a*_i        S1 pixels of this channel
//   rnd_i       round flag aligned with the S2 products
//   b_o         S3 result of this channel
module pe_bilinear_lane #(
  parameter int DWIDTH = 8,
  parameter int FWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [2*FWIDTH:0]     w00_i,
  input  logic [2*FWIDTH:0]     w01_i,
  input  logic [2*FWIDTH:0]     w10_i,
  input  logic [2*FWIDTH:0]     w11_i,
  input  logic [DWIDTH-1:0]     a00_i,
  input  logic [DWIDTH-1:0]     a01_i,
  input  logic [DWIDTH-1:0]     a10_i,
  input  logic [DWIDTH-1:0]     a11_i,
  input  logic                  rnd_i,
  output logic [DWIDTH-1:0]     b_o
);
  localparam int PW = 2*FWIDTH + DWIDTH + 1;
  localparam int SW = PW + 1;

  logic [PW-1:0]     p00_q, p01_q, p10_q, p11_q;
  logic [SW-1:0]     sum;
  logic [DWIDTH+1:0] q;
  logic [DWIDTH-1:0] b_d, b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p00_q <= '0;
      p01_q <= '0;
      p10_q <= '0;
      p11_q <= '0;
      b_q   <= '0;
    end else if (en_i) begin
      p00_q <= PW'(w00_i) * PW'(a00_i);
      p01_q <= PW'(w01_i) * PW'(a01_i);
      p10_q <= PW'(w10_i) * PW'(a10_i);
      p11_q <= PW'(w11_i) * PW'(a11_i);
      b_q   <= b_d;
    end
  end

  always_comb begin
    sum = SW'(p00_q) + SW'(p01_q) + SW'(p10_q) + SW'(p11_q);
    if (rnd_i) sum = sum + (SW'(1) << (2*FWIDTH-1));
    q = sum[SW-1:2*FWIDTH];
    // Weights sum to exactly 2^(2*FWIDTH), so q can only exceed full scale
    // through the rounding offset on illegal inputs; clip anyway.
    b_d = (|q[DWIDTH+1:DWIDTH]) ? '1 : q[DWIDTH-1:0];
  end

  assign b_o = b_q;
endmodule

module pe_bilinear_pipe #(
  parameter int DWIDTH = 8,
  parameter int FWIDTH = 16,
  parameter int CH     = 1,
  parameter int TWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DWIDTH-1:0] a00,
  input  logic [CH*DWIDTH-1:0] a01,
  input  logic [CH*DWIDTH-1:0] a10,
  input  logic [CH*DWIDTH-1:0] a11,
  input  logic [FWIDTH-1:0]    fx,
  input  logic [FWIDTH-1:0]    fy,
  input  logic                 round_en,
  input  logic [TWIDTH-1:0]    in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DWIDTH-1:0] b,
  output logic [TWIDTH-1:0]    out_tag
);
  localparam int WW = 2*FWIDTH + 1;

  typedef struct packed {
    logic [WW-1:0] w00;
    logic [WW-1:0] w01;
    logic [WW-1:0] w10;
    logic [WW-1:0] w11;
  } wgt_t;

  typedef struct packed {
    logic              rnd;
    logic [TWIDTH-1:0] tag;
  } side_t;

  logic                         en;
  logic [3:1]                   vld_pipe_q;
  logic [FWIDTH:0]              wx1, wy1;
  wgt_t                         wgt_d, wgt_q;
  logic [CH-1:0][DWIDTH-1:0]    a00_q, a01_q, a10_q, a11_q;
  side_t                        side1_q, side2_q;
  logic [TWIDTH-1:0]            out_tag_q;
  logic [CH-1:0][DWIDTH-1:0]    b_lane;

  assign en       = !vld_pipe_q[3] | out_ready;
  assign in_ready = en;

  // 1 - f in FWIDTH+1 bits; fx < 1.0 so this never underflows.
  assign wx1 = {1'b1, {FWIDTH{1'b0}}} - {1'b0, fx};
  assign wy1 = {1'b1, {FWIDTH{1'b0}}} - {1'b0, fy};

  always_comb begin
    wgt_d     = '0;
    // Max product is exactly 2^(2*FWIDTH) (fx=fy=0), which fits WW bits.
    wgt_d.w00 = WW'(wx1) * WW'(wy1);
    wgt_d.w01 = WW'(wy1) * WW'(fx);
    wgt_d.w10 = WW'(fy)  * WW'(wx1);
    wgt_d.w11 = WW'(fy)  * WW'(fx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      wgt_q      <= '0;
      a00_q      <= '0;
      a01_q      <= '0;
      a10_q      <= '0;
      a11_q      <= '0;
      side1_q    <= '0;
      side2_q    <= '0;
      out_tag_q  <= '0;
    end else if (en) begin
      vld_pipe_q <= {vld_pipe_q[2:1], in_valid};
      wgt_q      <= wgt_d;
      a00_q      <= a00;
      a01_q      <= a01;
      a10_q      <= a10;
      a11_q      <= a11;
      side1_q    <= '{rnd: round_en, tag: in_tag};
      side2_q    <= side1_q;
      out_tag_q  <= side2_q.tag;
    end
  end

  pe_bilinear_lane #(.DWIDTH(DWIDTH), .FWIDTH(FWIDTH)) u_lane [CH-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (en),
    .w00_i (wgt_q.w00),
    .w01_i (wgt_q.w01),
    .w10_i (wgt_q.w10),
    .w11_i (wgt_q.w11),
    .a00_i (a00_q),
    .a01_i (a01_q),
    .a10_i (a10_q),
    .a11_i (a11_q),
    .rnd_i (side2_q.rnd),
    .b_o   (b_lane)
  );

  assign out_valid = vld_pipe_q[3];
  assign b         = b_lane;
  assign out_tag   = out_tag_q;
endmodule

// File: tb/tb_pe_bilinear_pipe.sv
module tb_pe_bilinear_pipe;
  localparam int DW = 8;
  localparam int FW = 16;
  localparam int CH = 2;
  localparam int TW = 8;

  logic             clk, rst_n;
  logic             in_valid, in_ready, out_valid, out_ready, round_en;
  logic [CH*DW-1:0] a00, a01, a10, a11, b;
  logic [FW-1:0]    fx, fy;
  logic [TW-1:0]    in_tag, out_tag;

  typedef struct {
    logic [CH*DW-1:0] b;
    logic [TW-1:0]    tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  pe_bilinear_pipe #(.DWIDTH(DW), .FWIDTH(FW), .CH(CH), .TWIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11), .fx(fx), .fy(fy),
    .round_en(round_en), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .b(b), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer bilinear blend per channel.
  function automatic logic [CH*DW-1:0] model(
    input logic [CH*DW-1:0] p00, p01, p10, p11,
    input logic [FW-1:0] f_x, f_y, input logic rnd);
    longint w, x1, y1, s, q;
    logic [CH*DW-1:0] r;
    w  = longint'(1) << FW;
    x1 = w - longint'(f_x);
    y1 = w - longint'(f_y);
    r  = '0;
    for (int k = 0; k < CH; k++) begin
      s = x1 * y1 * longint'(p00[k*DW +: DW]) + y1 * longint'(f_x) * longint'(p01[k*DW +: DW])
        + longint'(f_y) * x1 * longint'(p10[k*DW +: DW])
        + longint'(f_y) * longint'(f_x) * longint'(p11[k*DW +: DW]);
      if (rnd) s = s + (longint'(1) << (2*FW-1));
      q = s >>> (2*FW);
      if (q > 255) q = 255;
      r[k*DW +: DW] = q[DW-1:0];
    end
    return r;
  endfunction

  // Present one beat, wait for acceptance, push its expected result.
  task automatic send(input logic [CH*DW-1:0] p00, p01, p10, p11,
                      input logic [FW-1:0] f_x, f_y, input logic rnd,
                      input logic [TW-1:0] tg, input logic [CH*DW-1:0] eb);
    exp_t e;
    a00 = p00; a01 = p01; a10 = p10; a11 = p11;
    fx = f_x; fy = f_y; round_en = rnd; in_tag = tg; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.b = eb; e.tag = tg;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL send_timeout tag=%0d in_ready=%b, required 1", tg, in_ready);
    in_valid = 1'b0;
  endtask

  // Scoreboard: every transferred output beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected b=%h tag=%h, required no output", b, out_tag);
      end else begin
        mon_e = sb.pop_front();
        if (b !== mon_e.b || out_tag !== mon_e.tag) begin
          errors++;
          $display("FAIL sb_data b=%h tag=%h, required b=%h tag=%h", b, out_tag, mon_e.b, mon_e.tag);
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; round_en = 1'b0;
    a00 = '0; a01 = '0; a10 = '0; a11 = '0; fx = '0; fy = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b, required 0", out_valid); end
    checks++; if (b !== '0) begin errors++; $display("FAIL rst_b got %h, required 0", b); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL rst_out_tag got %h, required 0", out_tag); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b, required 1", in_ready); end
  endtask

  task automatic test_latency();
    send({8'd50, 8'd200}, '0, '0, '0, 16'h0000, 16'h0000, 1'b1, 8'hA5, {8'd50, 8'd200});
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early out_valid=%b, required 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || b !== {8'd50, 8'd200} || out_tag !== 8'hA5) begin
      errors++;
      $display("FAIL lat_n3 valid=%b b=%h tag=%h, required 1 %h a5", out_valid, b, out_tag, {8'd50, 8'd200});
    end
    drain();
  endtask

  task automatic test_round_modes();
    send({8'd10, 8'd10}, {8'd11, 8'd11}, '0, '0, 16'h8000, 16'h0000, 1'b1, 8'h02, {8'd11, 8'd11});
    send({8'd10, 8'd10}, {8'd11, 8'd11}, '0, '0, 16'h8000, 16'h0000, 1'b0, 8'h03, {8'd10, 8'd10});
    send('0, {2{8'd255}}, {2{8'd255}}, {2{8'd255}}, 16'h8000, 16'h8000, 1'b1, 8'h04, {8'd191, 8'd191});
    send('0, {2{8'd255}}, {2{8'd255}}, {2{8'd255}}, 16'h8000, 16'h8000, 1'b0, 8'h05, {8'd191, 8'd191});
    send({2{8'd255}}, {2{8'd255}}, {2{8'd255}}, {2{8'd255}}, 16'h7FFF, 16'h7FFF, 1'b1, 8'h06, {8'd255, 8'd255});
    send({8'd77, 8'd3}, {8'd9, 8'd9}, {8'd9, 8'd9}, {8'd9, 8'd9}, 16'h0000, 16'h0000, 1'b0, 8'h07, {8'd77, 8'd3});
    drain();
  endtask

  task automatic test_channels();
    send({8'd100, 8'd0}, {8'd0, 8'd100}, '0, '0, 16'hC000, 16'h0000, 1'b0, 8'h08, {8'd25, 8'd75});
    drain();
  endtask

  task automatic test_back_to_back();
    logic [CH*DW-1:0] hb;
    logic [TW-1:0]    ht;
    bit               seen;
    fork
      begin
        for (int t = 1; t <= 6; t++) begin
          logic [CH*DW-1:0] p0, p1, p2, p3;
          logic [FW-1:0]    f0, f1;
          p0 = CH*DW'($urandom); p1 = CH*DW'($urandom);
          p2 = CH*DW'($urandom); p3 = CH*DW'($urandom);
          f0 = FW'($urandom); f1 = FW'($urandom);
          send(p0, p1, p2, p3, f0, f1, t[0], TW'(t), model(p0, p1, p2, p3, f0, f1, t[0]));
        end
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(posedge clk); #1;
          if (out_valid && out_tag == 8'd1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
          errors++;
          $display("FAIL bp_first tag 1 never seen, required within 50 cycles");
        end else begin
          out_ready = 1'b0;
          hb = b; ht = out_tag;
          repeat (4) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || b !== hb || out_tag !== ht) begin
              errors++;
              $display("FAIL bp_stall in_ready=%b valid=%b b=%h tag=%h, required 0 1 %h %h",
                       in_ready, out_valid, b, out_tag, hb, ht);
            end
          end
          @(posedge clk); #1;
          out_ready = 1'b1;
          for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
              errors++;
              $display("FAIL bp_rate cycle %0d out_valid=%b, required 1", i, out_valid);
            end
          end
        end
      end
    join
    drain();
  endtask

  task automatic test_reset_mid();
    send({8'd1, 8'd2}, '0, '0, '0, '0, '0, 1'b0, 8'h31, {8'd1, 8'd2});
    send({8'd3, 8'd4}, '0, '0, '0, '0, '0, 1'b0, 8'h32, {8'd3, 8'd4});
    send({8'd5, 8'd6}, '0, '0, '0, '0, '0, 1'b0, 8'h33, {8'd5, 8'd6});
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || b !== '0 || out_tag !== '0) begin
      errors++;
      $display("FAIL rstmid_async valid=%b b=%h tag=%h, required 0 0 0", out_valid, b, out_tag);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b, required 1", in_ready); end
    send({8'd42, 8'd24}, '0, '0, '0, '0, '0, 1'b1, 8'h40, {8'd42, 8'd24});
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale out_valid=%b, required 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 8'h40) begin
      errors++;
      $display("FAIL rstmid_lat valid=%b tag=%h, required 1 40", out_valid, out_tag);
    end
    drain();
  endtask

  task automatic test_random();
    fork
      begin
        for (int t = 0; t < 24; t++) begin
          logic [CH*DW-1:0] p0, p1, p2, p3;
          logic [FW-1:0]    f0, f1;
          logic             r;
          p0 = CH*DW'($urandom); p1 = CH*DW'($urandom);
          p2 = CH*DW'($urandom); p3 = CH*DW'($urandom);
          f0 = FW'($urandom); f1 = FW'($urandom); r = 1'($urandom);
          send(p0, p1, p2, p3, f0, f1, r, TW'(8'h80 + t), model(p0, p1, p2, p3, f0, f1, r));
          repeat ($urandom_range(0, 1)) @(posedge clk);
          #0;
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_round_modes();
    test_channels();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
